// File: rtl/axis_arb_pkg.sv
// ---------------------------------------------------------------------------
// axis_arb_pkg
//
// Shared definitions for the AXI4-Stream burst arbiter and any other arbiter
// that wants the same round-robin selection.
//
// Contents:
//   arb_state_e    - two-state scheduler FSM encoding (ARB_IDLE, ARB_XFER)
//   MAX_SRC        - widest request vector the helper functions accept
//   MAX_IDX_W      - index width matching MAX_SRC
//   rr_pick        - round-robin pick: first set request bit at or above
//                    ptr, wrapping around; returns a one-hot grant
//   onehot_to_idx  - binary index of the set bit of a one-hot vector
//
// The helpers work on the fixed MAX_SRC width. Narrower callers zero-extend
// their request vector. Request bits above the caller's source count are
// zero, so wrapping modulo MAX_SRC gives the same answer as wrapping modulo
// the caller's own source count.
// ---------------------------------------------------------------------------
package axis_arb_pkg;

    localparam int MAX_SRC   = 16;
    localparam int MAX_IDX_W = 4;

    typedef enum logic [0:0] {
        ARB_IDLE = 1'b0,
        ARB_XFER = 1'b1
    } arb_state_e;

    function automatic logic [MAX_SRC-1:0] rr_pick(
        input logic [MAX_SRC-1:0]   req,
        input logic [MAX_IDX_W-1:0] ptr
    );
        logic [MAX_SRC-1:0]   gnt;
        logic                 found;
        logic [MAX_IDX_W-1:0] idx;
        gnt   = '0;
        found = 1'b0;
        for (int i = 0; i < MAX_SRC; i++) begin
            // The index is 4 bits wide, so ptr + i wraps naturally.
            idx = ptr + MAX_IDX_W'(i);
            if (!found && req[idx]) begin
                gnt[idx] = 1'b1;
                found    = 1'b1;
            end
        end
        return gnt;
    endfunction

    function automatic logic [MAX_IDX_W-1:0] onehot_to_idx(
        input logic [MAX_SRC-1:0] oh
    );
        logic [MAX_IDX_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < MAX_SRC; i++) begin
            if (oh[i]) begin
                idx = idx | MAX_IDX_W'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/axis_rr_picker.sv
// ---------------------------------------------------------------------------
// axis_rr_picker
//
// Purely combinational round-robin picker. It searches upward from ptr,
// modulo NUM_SRC, and returns the first active request as a one-hot grant.
//
// Parameters:
//   NUM_SRC  number of requesters (2..16)
//   PTR_W    width of the search-start pointer
//
// Ports:
//   req    in   NUM_SRC   request vector
//   ptr    in   PTR_W     index at which the search starts (< NUM_SRC)
//   gnt    out  NUM_SRC   one-hot grant; all zeros when req == 0
//   valid  out  1         a grant is offered (at least one request)
// ---------------------------------------------------------------------------
module axis_rr_picker
    import axis_arb_pkg::*;
#(
    parameter int NUM_SRC = 4,
    parameter int PTR_W   = 2
) (
    input  logic [NUM_SRC-1:0] req,
    input  logic [PTR_W-1:0]   ptr,
    output logic [NUM_SRC-1:0] gnt,
    output logic               valid
);

    logic [MAX_SRC-1:0]   req_ext;
    logic [MAX_SRC-1:0]   gnt_ext;
    logic [MAX_IDX_W-1:0] ptr_ext;

    always_comb begin
        req_ext                = '0;
        req_ext[NUM_SRC-1:0]   = req;
        ptr_ext                = '0;
        ptr_ext[PTR_W-1:0]     = ptr;
        gnt_ext                = rr_pick(req_ext, ptr_ext);
        gnt                    = gnt_ext[NUM_SRC-1:0];
        // The upper grant bits are always zero because the matching request
        // bits are zero. Reducing the whole vector still gives "any request".
        valid                  = |gnt_ext;
    end

endmodule

// File: rtl/axis_burst_arbiter.sv
// ---------------------------------------------------------------------------
// axis_burst_arbiter
//
// Round-robin scheduler that shares one AXI4-Stream master port among
// NUM_SRC stream sources. A granted source owns the port for exactly
// BURST_LEN beats. The last beat is marked with m_axis_tlast and every beat
// carries the source index on m_axis_tid. After the burst the arbiter spends
// one idle cycle re-arbitrating, starting the search at the source after the
// one just served.
//
// Handshake: a beat moves on any rising edge where valid and ready are both
// high on the same interface. While a source is granted, the master side is
// a combinational pass-through of that source: its tvalid and tdata go out,
// and the sink's tready comes back to it alone. Ungranted sources always see
// tready low. A burst is never preempted: if the granted source drops
// tvalid, the port simply idles until it returns.
//
// Parameters:
//   NUM_SRC    number of sources (2..16)
//   DATA_W     tdata width
//   BURST_LEN  beats per grant (>= 1)
//
// Ports:
//   clk            in   1               rising-edge clock
//   rst            in   1               synchronous active-high reset
//   s_axis_tdata   in   NUM_SRC*DATA_W  source k at [k*DATA_W +: DATA_W]
//   s_axis_tvalid  in   NUM_SRC         per-source valid
//   s_axis_tready  out  NUM_SRC         per-source ready
//   m_axis_tdata   out  DATA_W          data of the granted source
//   m_axis_tvalid  out  1               master valid
//   m_axis_tready  in   1               sink ready
//   m_axis_tlast   out  1               final beat of the burst
//   m_axis_tid     out  clog2(NUM_SRC)  index of the granted source
//   grant          out  NUM_SRC         one-hot grant, zero while idle
//   busy           out  1               FSM is in ARB_XFER (state debug view)
//   burst_cnt      out  NUM_SRC*16      present only with AXIS_ARB_STATS_EN:
//                                       per-source count of completed bursts,
//                                       wrapping at 16 bits
//
// Build option: define AXIS_ARB_STATS_EN to add the burst_cnt statistics.
// ---------------------------------------------------------------------------
module axis_burst_arbiter
    import axis_arb_pkg::*;
#(
    parameter int NUM_SRC   = 4,
    parameter int DATA_W    = 32,
    parameter int BURST_LEN = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_SRC*DATA_W-1:0]   s_axis_tdata,
    input  logic [NUM_SRC-1:0]          s_axis_tvalid,
    output logic [NUM_SRC-1:0]          s_axis_tready,
    output logic [DATA_W-1:0]           m_axis_tdata,
    output logic                        m_axis_tvalid,
    input  logic                        m_axis_tready,
    output logic                        m_axis_tlast,
    output logic [$clog2(NUM_SRC)-1:0]  m_axis_tid,
    output logic [NUM_SRC-1:0]          grant,
    output logic                        busy
`ifdef AXIS_ARB_STATS_EN
    ,
    output logic [NUM_SRC*16-1:0]       burst_cnt
`endif
);

    localparam int ID_W  = $clog2(NUM_SRC);
    localparam int CNT_W = $clog2(BURST_LEN + 1);

    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BURST_LEN - 1);
    localparam logic [ID_W-1:0]  LAST_SRC  = ID_W'(NUM_SRC - 1);

    arb_state_e         state;
    logic [NUM_SRC-1:0] grant_q;
    logic [CNT_W-1:0]   beat_cnt;
    logic [ID_W-1:0]    rr_ptr;

    logic [NUM_SRC-1:0] pick_gnt;
    logic               pick_valid;
    logic [ID_W-1:0]    sel_idx;
    logic               in_xfer;
    logic               beat_fire;
    logic               last_beat;

    // ---------------------------------------------------------------------
    // Round-robin selection over the live requests
    // ---------------------------------------------------------------------
    axis_rr_picker #(
        .NUM_SRC (NUM_SRC),
        .PTR_W   (ID_W)
    ) u_picker (
        .req   (s_axis_tvalid),
        .ptr   (rr_ptr),
        .gnt   (pick_gnt),
        .valid (pick_valid)
    );

    // ---------------------------------------------------------------------
    // Datapath: pass-through of the granted source. grant_q is zero while
    // idle, so every masked term below falls to zero without a state check.
    // ---------------------------------------------------------------------
    always_comb begin
        sel_idx      = '0;
        m_axis_tdata = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            if (grant_q[k]) begin
                sel_idx      = sel_idx | ID_W'(k);
                m_axis_tdata = m_axis_tdata | s_axis_tdata[k*DATA_W +: DATA_W];
            end
        end
    end

    assign in_xfer       = (state == ARB_XFER);
    assign m_axis_tvalid = |(s_axis_tvalid & grant_q);
    assign s_axis_tready = grant_q & {NUM_SRC{m_axis_tready}};
    assign last_beat     = in_xfer && (beat_cnt == LAST_BEAT);
    assign beat_fire     = m_axis_tvalid & m_axis_tready;

    assign m_axis_tlast  = last_beat;
    assign m_axis_tid    = sel_idx;
    assign grant         = grant_q;
    assign busy          = in_xfer;

    // ---------------------------------------------------------------------
    // Scheduler FSM
    // ---------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ARB_IDLE;
            grant_q  <= '0;
            beat_cnt <= '0;
            rr_ptr   <= '0;
        end else begin
            case (state)
                ARB_IDLE: begin
                    // Requests are only looked at here, so a source that
                    // asserts tvalid mid-burst waits for the next idle cycle.
                    if (pick_valid) begin
                        grant_q <= pick_gnt;
                        state   <= ARB_XFER;
                    end
                end
                ARB_XFER: begin
                    // The counter only moves on accepted beats. A stalled or
                    // paused source therefore holds the burst where it is.
                    if (beat_fire) begin
                        if (last_beat) begin
                            beat_cnt <= '0;
                            grant_q  <= '0;
                            state    <= ARB_IDLE;
                            rr_ptr   <= (sel_idx == LAST_SRC) ? '0 : sel_idx + 1'b1;
                        end else begin
                            beat_cnt <= beat_cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    state   <= ARB_IDLE;
                    grant_q <= '0;
                end
            endcase
        end
    end

`ifdef AXIS_ARB_STATS_EN
    // ---------------------------------------------------------------------
    // Per-source completed-burst counters. A count is taken only on the
    // tlast beat, so a burst cut short by reset never counts.
    // ---------------------------------------------------------------------
    logic [15:0] stat_q [NUM_SRC];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < NUM_SRC; k++) begin
                stat_q[k] <= '0;
            end
        end else if (beat_fire && last_beat) begin
            for (int k = 0; k < NUM_SRC; k++) begin
                if (grant_q[k]) begin
                    stat_q[k] <= stat_q[k] + 16'd1;
                end
            end
        end
    end

    always_comb begin
        burst_cnt = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            burst_cnt[k*16 +: 16] = stat_q[k];
        end
    end
`endif

endmodule
